uart_time_reporter: RTL and testbench
=====================================

Name: uart_time_reporter

Overview:
- Transmit-side counterpart of the UART command decoder.
- On a report request, snapshots the current hour/min/sec and sends them as ASCII text "HH:MM:SS" plus optional CR LF.
- Bytes go out one at a time through the existing UART transmitter's start/busy/done handshake.
- Sits between the clock/stopwatch datapath and uart_tx, so a PC terminal can read the time back.

Parameters:
- SEND_CRLF, 1, when 1 append 8'h0D 8'h0A after the seconds digits (10 bytes total); when 0 send 8 bytes.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- report_req  input  1  request a report; sampled only in IDLE
- hour  input  5  hour value, 0..31 accepted and printed as-is
- min  input  6  minute value, 0..63 printed as-is
- sec  input  6  second value, 0..63 printed as-is
- tx_busy  input  1  uart_tx busy flag
- tx_done  input  1  uart_tx one-cycle pulse when a byte has finished
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data
- tx_data  output  8  byte to transmit
- report_busy  output  1  high from request acceptance until the last byte's tx_done
- report_done  output  1  one-cycle pulse after the last byte completes

Behaviour:
- Reset values: tx_start=0, tx_data=8'h00, report_busy=0, report_done=0; state=IDLE; byte index=0; snapshot registers=0.
- All outputs are registered.
- Byte sequence, index 0..9:
  - 0: hour tens, 1: hour ones, 2: ':' (8'h3A)
  - 3: min tens, 4: min ones, 5: ':' (8'h3A)
  - 6: sec tens, 7: sec ones
  - 8: 8'h0D, 9: 8'h0A (only when SEND_CRLF=1)
- Digit conversion: ASCII = 8'h30 + digit; tens = value/10, ones = value%10 (e.g. 63 -> "63", 5 -> "05").
- Last index: LAST = 9 if SEND_CRLF else 7.
- State machine:
  - IDLE: report_busy=0. If report_req=1, latch hour/min/sec into the snapshot, set index=0, report_busy<=1, go to SEND.
  - SEND: wait while tx_busy=1. When tx_busy=0, register tx_data<=byte[index] and tx_start<=1 for exactly one cycle, then go to WAIT.
  - WAIT: tx_start=0. tx_data is held stable until tx_done. On tx_done:
    - if index==LAST: report_busy<=0, report_done<=1 for one cycle, go to IDLE;
    - otherwise index<=index+1 and go to SEND.
  - tx_done seen outside WAIT is ignored.
- Latency:
  - report_req to first tx_start: 2 cycles when tx_busy=0 (IDLE->SEND capture, SEND->tx_start).
  - tx_done to next tx_start: 2 cycles when tx_busy=0.
- Snapshot: changes on hour/min/sec after acceptance do not affect the report in progress.
- report_req while report_busy=1 is ignored, not queued.
- report_req in the same cycle as report_done is ignored. A new request is accepted no earlier than the cycle after report_done.
- A held-high report_req starts a new report each time the FSM returns to IDLE.
- rst mid-report aborts immediately. All outputs return to reset values on the next edge and the remaining bytes are dropped. uart_tx is reset by the same rst.

Decomposition:
- Shared package uart_pkg holds:
  - ASCII constants: ASC_ZERO=8'h30, ASC_COLON=8'h3A, ASC_CR=8'h0D, ASC_LF=8'h0A
  - state encoding: IDLE=0, SEND=1, WAIT=2 (2 bits)
- One natural sub-module: bin2ascii2, a combinational 6-bit value to two ASCII digit bytes (tens, ones). It is instantiated three times on the snapshot registers.

Test Plan:
- Basic report:
  - Stimulus: hour=13, min=5, sec=42, SEND_CRLF=1, uart_tx model with done 10 cycles after start; pulse report_req.
  - Required: exactly 10 tx_start pulses with data 31 33 3A 30 35 3A 34 32 0D 0A; report_done one cycle after the last tx_done; report_busy low afterwards.
- No CRLF, extremes:
  - Stimulus: SEND_CRLF=0, hour=31, min=63, sec=0.
  - Required: 8 bytes 33 31 3A 36 33 3A 30 30, then report_done.
- Snapshot hold:
  - Stimulus: change sec from 42 to 43 immediately after acceptance.
  - Required: bytes 6 and 7 are still 34 32.
- Busy and request filtering:
  - Stimulus: hold tx_busy=1 for 20 cycles at start; pulse report_req again mid-report.
  - Required: no tx_start while tx_busy=1; second request ignored; only 10 bytes total.
- Reset mid-report:
  - Stimulus: assert rst after byte 4's tx_start.
  - Required: next cycle tx_start=0, tx_data=00, report_busy=0, no further bytes.
  - Follow-up: a new report_req then produces the full sequence from byte 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, reporter FSM encoding and the time snapshot payload.
package uart_pkg;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_snap_t;

endpackage

// File: rtl/bin2ascii2.sv
// Converts a 0..63 binary value into its two decimal ASCII digits (tens, ones).
module bin2ascii2
  import uart_pkg::*;
(
  input  logic [5:0] value,
  output logic [7:0] tens_c,
  output logic [7:0] ones_c
);

  logic [5:0] tens_d;
  logic [5:0] ones_d;

  always_comb begin
    tens_d = value / 6'd10;
    ones_d = value % 6'd10;
    tens_c = ASC_ZERO + {2'b00, tens_d};
    ones_c = ASC_ZERO + {2'b00, ones_d};
  end

endmodule

// File: rtl/uart_time_reporter.sv
// Snapshots hour/min/sec on request and streams "HH:MM:SS" (+ optional CR LF) through uart_tx.
module uart_time_reporter
  import uart_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              report_req,
  input  logic [HOUR_W-1:0] hour,
  input  logic [MIN_W-1:0]  min,
  input  logic [SEC_W-1:0]  sec,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              report_busy,
  output logic              report_done
);

  localparam logic [IDX_W-1:0] LAST = SEND_CRLF ? 4'd9 : 4'd7;

  state_t           state;
  logic [IDX_W-1:0] idx;
  time_snap_t       snap;

  logic [7:0] hour_tens_c, hour_ones_c;
  logic [7:0] min_tens_c,  min_ones_c;
  logic [7:0] sec_tens_c,  sec_ones_c;
  logic [7:0] cur_byte_c;

  bin2ascii2 u_hour (
    .value  ({1'b0, snap.hour}),
    .tens_c (hour_tens_c),
    .ones_c (hour_ones_c)
  );

  bin2ascii2 u_min (
    .value  (snap.min),
    .tens_c (min_tens_c),
    .ones_c (min_ones_c)
  );

  bin2ascii2 u_sec (
    .value  (snap.sec),
    .tens_c (sec_tens_c),
    .ones_c (sec_ones_c)
  );

  // Byte selected by the current transmit index.
  always_comb begin
    cur_byte_c = 8'h00;
    case (idx)
      4'd0:    cur_byte_c = hour_tens_c;
      4'd1:    cur_byte_c = hour_ones_c;
      4'd2:    cur_byte_c = ASC_COLON;
      4'd3:    cur_byte_c = min_tens_c;
      4'd4:    cur_byte_c = min_ones_c;
      4'd5:    cur_byte_c = ASC_COLON;
      4'd6:    cur_byte_c = sec_tens_c;
      4'd7:    cur_byte_c = sec_ones_c;
      4'd8:    cur_byte_c = ASC_CR;
      4'd9:    cur_byte_c = ASC_LF;
      default: cur_byte_c = 8'h00;
    endcase
  end

  // Report FSM; a request landing on the report_done cycle is deliberately dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      snap        <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      report_busy <= 1'b0;
      report_done <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      report_done <= 1'b0;
      case (state)
        IDLE: begin
          if (report_req && !report_done) begin
            snap.hour   <= hour;
            snap.min    <= min;
            snap.sec    <= sec;
            idx         <= '0;
            report_busy <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= cur_byte_c;
            tx_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (idx == LAST) begin
              report_busy <= 1'b0;
              report_done <= 1'b1;
              state       <= IDLE;
            end else begin
              idx   <= idx + 4'd1;
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: CRLF and no-CRLF instances side by side, each with its own uart_tx model.
module tb_uart_time_reporter;

  localparam int DONE_DLY = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0, sec = '0;
  logic       hold_busy = 1'b0;

  logic       m_busy0 = 1'b0, m_busy1 = 1'b0;
  logic       tx_done0 = 1'b0, tx_done1 = 1'b0;
  logic       tx_busy0, tx_busy1;
  logic       tx_start0, tx_start1;
  logic [7:0] tx_data0, tx_data1;
  logic       rbusy0, rbusy1, rdone0, rdone1;
  int         cnt0 = 0, cnt1 = 0;

  always #5 clk = ~clk;

  assign tx_busy0 = m_busy0 | hold_busy;
  assign tx_busy1 = m_busy1 | hold_busy;

  uart_time_reporter #(.SEND_CRLF(1'b1)) dut_crlf (
    .clk(clk), .rst(rst), .report_req(req0), .hour(hour), .min(min), .sec(sec),
    .tx_busy(tx_busy0), .tx_done(tx_done0), .tx_start(tx_start0), .tx_data(tx_data0),
    .report_busy(rbusy0), .report_done(rdone0)
  );

  uart_time_reporter #(.SEND_CRLF(1'b0)) dut_nocrlf (
    .clk(clk), .rst(rst), .report_req(req1), .hour(hour), .min(min), .sec(sec),
    .tx_busy(tx_busy1), .tx_done(tx_done1), .tx_start(tx_start1), .tx_data(tx_data1),
    .report_busy(rbusy1), .report_done(rdone1)
  );

  // uart_tx models: busy after a start, done pulse DONE_DLY cycles later.
  always @(posedge clk) begin
    if (rst) begin
      m_busy0 <= 1'b0; tx_done0 <= 1'b0; cnt0 <= 0;
    end else begin
      tx_done0 <= 1'b0;
      if (tx_start0) begin
        m_busy0 <= 1'b1; cnt0 <= DONE_DLY;
      end else if (m_busy0) begin
        if (cnt0 == 1) begin m_busy0 <= 1'b0; tx_done0 <= 1'b1; end
        cnt0 <= cnt0 - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy1 <= 1'b0; tx_done1 <= 1'b0; cnt1 <= 0;
    end else begin
      tx_done1 <= 1'b0;
      if (tx_start1) begin
        m_busy1 <= 1'b1; cnt1 <= DONE_DLY;
      end else if (m_busy1) begin
        if (cnt1 == 1) begin m_busy1 <= 1'b0; tx_done1 <= 1'b1; end
        cnt1 <= cnt1 - 1;
      end
    end
  end

  // Monitor: byte capture, done timing, starts issued while the transmitter was busy.
  logic [7:0] q0[$], q1[$];
  int cyc = 0;
  int dcnt0 = 0, dcnt1 = 0;
  int last_tx_done0 = 0, last_tx_done1 = 0, done_cyc0 = 0, done_cyc1 = 0;
  int bad_start = 0;
  logic busy_prev0 = 1'b0, busy_prev1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start0) begin
      q0.push_back(tx_data0);
      if (busy_prev0) bad_start <= bad_start + 1;
    end
    if (tx_start1) begin
      q1.push_back(tx_data1);
      if (busy_prev1) bad_start <= bad_start + 1;
    end
    if (tx_done0) last_tx_done0 <= cyc;
    if (tx_done1) last_tx_done1 <= cyc;
    if (rdone0) begin dcnt0 <= dcnt0 + 1; done_cyc0 <= cyc; end
    if (rdone1) begin dcnt1 <= dcnt1 + 1; done_cyc1 <= cyc; end
    busy_prev0 <= tx_busy0;
    busy_prev1 <= tx_busy1;
  end

  int checks = 0;
  int errors = 0;
  int b0, b1, bd0, bd1;

  typedef struct {
    int          h;
    int          m;
    int          s;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: byte k of the report from decimal arithmetic on the three fields.
  function automatic logic [7:0] ref_byte(input int h, input int m, input int s, input int k);
    int vals[3];
    int digit;
    vals[0] = h; vals[1] = m; vals[2] = s;
    if (k == 8) return 8'h0D;
    if (k == 9) return 8'h0A;
    if (k % 3 == 2) return 8'h3A;
    digit = (k % 3 == 0) ? vals[k / 3] / 10 : vals[k / 3] % 10;
    return 8'(48 + digit);
  endfunction

  function automatic logic [79:0] model_seq(input int h, input int m, input int s);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[79-8*k -: 8] = ref_byte(h, m, s, k);
    return r;
  endfunction

  task automatic nwait();
    @(negedge clk); #1;
  endtask

  task automatic mark();
    b0 = q0.size(); b1 = q1.size(); bd0 = dcnt0; bd1 = dcnt1;
  endtask

  task automatic check_seq(input string name, input int which, input int base,
                           input logic [79:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] got;
      got = 8'hEE;
      if (which == 0) begin
        if (base + i < q0.size()) got = q0[base+i];
      end else begin
        if (base + i < q1.size()) got = q1[base+i];
      end
      check($sformatf("%s_i%0d_byte%0d", name, which, i), {24'h0, got}, {24'h0, exp[79-8*i -: 8]});
    end
  endtask

  task automatic check_report(input string name, input logic [79:0] exp);
    check({name, "_count_crlf"}, q0.size() - b0, 10);
    check({name, "_count_nocrlf"}, q1.size() - b1, 8);
    check_seq(name, 0, b0, exp, 10);
    check_seq(name, 1, b1, exp, 8);
    check({name, "_done_pulses_crlf"}, dcnt0 - bd0, 1);
    check({name, "_done_pulses_nocrlf"}, dcnt1 - bd1, 1);
    check({name, "_done_lat_crlf"}, done_cyc0 - last_tx_done0, 1);
    check({name, "_done_lat_nocrlf"}, done_cyc1 - last_tx_done1, 1);
    check({name, "_busy_after"}, {30'h0, rbusy0, rbusy1}, 0);
    check({name, "_start_while_busy"}, bad_start, 0);
  endtask

  task automatic do_report(input int h, input int m, input int s, input int sec_after,
                           input int busy_hold, input bit mid_req);
    int to;
    mark();
    hour = 5'(h); min = 6'(m); sec = 6'(s);
    hold_busy = (busy_hold > 0);
    @(posedge clk); #1 req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    if (sec_after >= 0) sec = 6'(sec_after);
    if (busy_hold > 0) begin
      repeat (busy_hold - 1) @(posedge clk);
      #1;
      check("busy_hold_no_start", q0.size() - b0 + q1.size() - b1, 0);
      hold_busy = 1'b0;
    end
    if (mid_req) begin
      to = 0;
      while (q0.size() - b0 < 5 && to < 2000) begin @(posedge clk); #1; to++; end
      req0 = 1'b1; req1 = 1'b1;
      @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    end
    to = 0;
    while (!(dcnt0 > bd0 && dcnt1 > bd1) && to < 3000) begin nwait(); to++; end
    repeat (2) nwait();
  endtask

  initial begin
    int to;
    int h, m, s;
    vecs[0] = '{13,  5, 42, 80'h31333A30353A34320D0A};
    vecs[1] = '{31, 63,  0, 80'h33313A36333A30300D0A};
    vecs[2] = '{ 0,  0,  0, 80'h30303A30303A30300D0A};
    vecs[3] = '{ 9, 59, 10, 80'h30393A35393A31300D0A};

    repeat (3) @(posedge clk);
    nwait();
    check("reset_outputs_crlf", {21'h0, tx_start0, tx_data0, rbusy0, rdone0}, 0);
    check("reset_outputs_nocrlf", {21'h0, tx_start1, tx_data1, rbusy1, rdone1}, 0);
    rst = 1'b0;
    repeat (2) nwait();

    // Directed vectors with hand-written expected bytes.
    for (int v = 0; v < 4; v++) begin
      do_report(vecs[v].h, vecs[v].m, vecs[v].s, -1, 0, 1'b0);
      check_report($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Snapshot hold: sec changes right after acceptance.
    do_report(13, 5, 42, 43, 0, 1'b0);
    check_report("snapshot", 80'h31333A30353A34320D0A);

    // Transmitter busy at start plus an ignored mid-report request.
    do_report(13, 5, 42, -1, 20, 1'b1);
    repeat (60) nwait();
    check_report("busy_filter", 80'h31333A30353A34320D0A);

    // Randomized reports against the reference model.
    for (int r = 0; r < 8; r++) begin
      h = int'($urandom_range(0, 31));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      do_report(h, m, s, -1, 0, 1'b0);
      check_report($sformatf("rand%0d", r), model_seq(h, m, s));
    end

    // Request coinciding with report_done must be dropped.
    mark();
    hour = 5'd7; min = 6'd8; sec = 6'd9;
    @(posedge clk); #1 req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    to = 0;
    while (!rdone0 && to < 3000) begin nwait(); to++; end
    req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    repeat (40) nwait();
    check("done_cycle_req_count", q0.size() - b0, 10);
    check("done_cycle_req_busy", {31'h0, rbusy0}, 0);

    // Held-high request restarts the cycle after report_done.
    mark();
    hour = 5'd22; min = 6'd33; sec = 6'd44;
    @(posedge clk); #1 req0 = 1'b1;
    to = 0;
    while (!rdone0 && to < 3000) begin nwait(); to++; end
    nwait();
    check("held_req_gap_busy", {31'h0, rbusy0}, 0);
    nwait();
    check("held_req_restart_busy", {31'h0, rbusy0}, 1);
    req0 = 1'b0;
    to = 0;
    while (dcnt0 - bd0 < 2 && to < 3000) begin nwait(); to++; end
    repeat (2) nwait();
    check("held_req_count", q0.size() - b0, 20);
    check_seq("held_req_second", 0, b0 + 10, model_seq(22, 33, 44), 10);

    // Reset right after byte 4 goes out.
    mark();
    hour = 5'd13; min = 6'd5; sec = 6'd42;
    @(posedge clk); #1 req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    to = 0;
    while (q0.size() - b0 < 5 && to < 2000) begin nwait(); to++; end
    rst = 1'b1;
    nwait();
    check("rst_mid_crlf", {21'h0, tx_start0, tx_data0, rbusy0, rdone0}, 0);
    check("rst_mid_nocrlf", {21'h0, tx_start1, tx_data1, rbusy1, rdone1}, 0);
    rst = 1'b0;
    repeat (40) nwait();
    check("rst_no_more_bytes", q0.size() - b0 + q1.size() - b1, 10);
    do_report(13, 5, 42, -1, 0, 1'b0);
    check_report("after_rst", 80'h31333A30353A34320D0A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
